// File: rtl/nios2_c_button_conditioner_pkg.sv
// Shared types for the pushbutton conditioner: FSM state encoding used by the
// top level and by anything that decodes its state.
package nios2_c_button_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

endpackage

// File: rtl/nios2_c_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit pin; the reset value
// is a parameter so the flops can idle at the pin's inactive level.
module nios2_c_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nios2_c_button_conditioner.sv
// Debounces a bouncy pushbutton into a clean level for the PIO edge capture,
// with press/release strobes, a long-press flag and a wrapping press count.
module nios2_c_button_conditioner
  import nios2_c_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int CNT_W             = 26,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       raw_in,
  output logic       clean_out,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output logic [7:0] press_count
);

  localparam logic             ACT_LOW   = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic sync_pin;
  logic pressed;

  // Synchroniser idles at the released pin level so reset never looks like a press.
  nios2_c_sync2 #(
    .RESET_VAL (ACT_LOW)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (raw_in),
    .q     (sync_pin)
  );

  assign pressed = sync_pin ^ ACT_LOW;

  btn_state_e       state_q,         state_d;
  logic [CNT_W-1:0] db_cnt_q,        db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q,      hold_cnt_d;
  logic             clean_q,         clean_d;
  logic             press_pulse_q,   press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             long_q,          long_d;
  logic [7:0]       count_q,         count_d;

  always_comb begin
    state_d         = state_q;
    db_cnt_d        = db_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    clean_d         = clean_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_d          = long_q;
    count_d         = count_q;

    case (state_q)
      ST_RELEASED: begin
        if (pressed) begin
          state_d  = ST_PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!pressed) begin
          state_d = ST_RELEASED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d       = ST_PRESSED;
          clean_d       = 1'b1;
          press_pulse_d = 1'b1;
          count_d       = count_q + 8'd1;
          hold_cnt_d    = '0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED, ST_RELEASE_WAIT: begin
        // Hold time accumulates across dropped release bounces.
        if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + CNT_ONE;
        if (hold_cnt_d == HOLD_LAST) long_d = 1'b1;
        if (state_q == ST_PRESSED) begin
          if (!pressed) begin
            state_d  = ST_RELEASE_WAIT;
            db_cnt_d = '0;
          end
        end else if (pressed) begin
          state_d = ST_PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d         = ST_RELEASED;
          clean_d         = 1'b0;
          release_pulse_d = 1'b1;
          long_d          = 1'b0;
          hold_cnt_d      = '0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = ST_RELEASED;
        clean_d    = 1'b0;
        long_d     = 1'b0;
        db_cnt_d   = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_RELEASED;
      db_cnt_q        <= '0;
      hold_cnt_q      <= '0;
      clean_q         <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_q          <= 1'b0;
      count_q         <= 8'd0;
    end else begin
      state_q         <= state_d;
      db_cnt_q        <= db_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      clean_q         <= clean_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_q          <= long_d;
      count_q         <= count_d;
    end
  end

  assign clean_out     = clean_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_press    = long_q;
  assign press_count   = count_q;

endmodule
